mask_read_arbiter: RTL and testbench

Shares the single read port of the 640×480 1-bit mask BRAM between two requesters on the 65 MHz domain. Requester 0 is the edge/corner finder and requester 1 is an overlay/readout client. The block arbitrates with sticky round-robin and a burst cap, and registers the winning address onto the BRAM port. It tracks every issued read through the BRAM latency and returns read data to the requester that issued it, with a per-requester valid strobe. It sits between the mask BRAM port B and its clients and replaces the direct `addr_corners` hookup.

---
 rtl/mask_arb_pkg.sv | 18 +
 rtl/rd_tag_pipe.sv | 26 ++
 rtl/mask_read_arbiter.sv | 99 +++++++++
 tb/tb_mask_read_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mask_arb_pkg.sv
// Shared types for the mask BRAM read arbiter: requester ids and the in-flight read tag.
package mask_arb_pkg;

  localparam int MASK_ADDR_W = 19;

  typedef enum logic {
    REQ_EDGE = 1'b0,
    REQ_AUX  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  localparam logic [7:0] BURST_SAT = 8'hFF;

endpackage

// File: rtl/rd_tag_pipe.sv
// LATENCY+1 stage shift register of read tags; follows each issued read through the BRAM.
module rd_tag_pipe
  import mask_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [LATENCY:0] pipe_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i <= LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[LATENCY];

endmodule

// File: rtl/mask_read_arbiter.sv
// Two-client arbiter for the mask BRAM read port: sticky round-robin with a burst cap.
// Build option MASK_ARB_FIXED_PRIORITY_EN makes requester 0 always win contention.
module mask_read_arbiter
  import mask_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = MASK_ADDR_W,
  parameter int DATA_WIDTH = 1,
  parameter int LATENCY    = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            req_in,
  input  logic [ADDR_WIDTH-1:0] addr0_in,
  input  logic [ADDR_WIDTH-1:0] addr1_in,
  output logic [1:0]            gnt_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic                  bram_en_out,
  input  logic [DATA_WIDTH-1:0] bram_data_in,
  output logic [1:0]            rvalid_out,
  output logic [DATA_WIDTH-1:0] rdata_out
);

  logic                  owner_q, owner_d;
  logic                  win;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  en_q;
  rd_tag_t               tag_in, tag_out;

`ifndef MASK_ARB_FIXED_PRIORITY_EN
  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  logic [7:0] burst_q, burst_d;
`endif

  always_comb begin
    gnt_out = 2'b00;
    win     = 1'b0;
    owner_d = owner_q;
`ifndef MASK_ARB_FIXED_PRIORITY_EN
    burst_d = burst_q;
`endif
    any_gnt = rst_in && (req_in != 2'b00);
    case (req_in)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
`ifdef MASK_ARB_FIXED_PRIORITY_EN
      2'b11:   win = 1'b0;
`else
      // burst_cnt==0 only occurs straight out of reset: no burst is running, so the
      // non-owner (requester 0, since owner resets to 1) takes the first contention.
      2'b11:   win = (burst_q != 8'd0 && burst_q < MAX_BURST_C) ? owner_q : ~owner_q;
`endif
      default: win = 1'b0;
    endcase
    if (any_gnt) begin
      gnt_out[win] = 1'b1;
      owner_d      = win;
`ifndef MASK_ARB_FIXED_PRIORITY_EN
      if (win != owner_q)         burst_d = 8'd1;
      else if (burst_q != BURST_SAT) burst_d = burst_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      owner_q <= 1'b1;
      addr_q  <= '0;
      en_q    <= 1'b0;
`ifndef MASK_ARB_FIXED_PRIORITY_EN
      burst_q <= 8'd0;
`endif
    end else begin
      owner_q <= owner_d;
      en_q    <= any_gnt;
      if (any_gnt) addr_q <= win ? addr1_in : addr0_in;
`ifndef MASK_ARB_FIXED_PRIORITY_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign tag_in = '{valid: any_gnt, id: req_id_t'(win)};

  rd_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bram_addr_out = addr_q;
  assign bram_en_out   = en_q;
  assign rvalid_out    = {tag_out.valid && tag_out.id == REQ_AUX,
                          tag_out.valid && tag_out.id == REQ_EDGE};
  assign rdata_out     = bram_data_in;

endmodule

// File: tb/tb_mask_read_arbiter.sv
// Directed bench for mask_read_arbiter; BRAM modelled as 2-cycle latency returning addr[0].
module tb_mask_read_arbiter;

  localparam int AW = 19;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [1:0]    req_in;
  logic [AW-1:0] addr0_in, addr1_in;
  logic [1:0]    gnt_out;
  logic [AW-1:0] bram_addr_out;
  logic          bram_en_out;
  logic          bram_data_in;
  logic [1:0]    rvalid_out;
  logic          rdata_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  mask_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(1), .LATENCY(2), .MAX_BURST(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_in        (req_in),
    .addr0_in      (addr0_in),
    .addr1_in      (addr1_in),
    .gnt_out       (gnt_out),
    .bram_addr_out (bram_addr_out),
    .bram_en_out   (bram_en_out),
    .bram_data_in  (bram_data_in),
    .rvalid_out    (rvalid_out),
    .rdata_out     (rdata_out)
  );

  // BRAM model: data at cycle t reflects the address presented at cycle t-2
  logic [AW-1:0] a1, a2;
  always @(posedge clk_in) begin
    a1 <= bram_addr_out;
    a2 <= a1;
  end
  assign bram_data_in = a2[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge; checks happen #3 later
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_in = 1'b0; req_in = 2'b00;
    cyc();
    rst_in = 1'b1;
  endtask

  logic       exp_id [0:19];
  logic [1:0] exp_g;

  initial begin
    rst_in = 1'b0; req_in = 2'b00; addr0_in = '0; addr1_in = '0;

    // reset held 3 cycles; gnt forced 0 even with requests in the last one
    cyc(); cyc(); cyc();
    req_in = 2'b11; #3;
    chk("rst_gnt", 32'(gnt_out), 32'h0);
    cyc(); rst_in = 1'b1; req_in = 2'b00; #3;
    chk("rst_en", 32'(bram_en_out), 32'h0);
    chk("rst_addr", 32'(bram_addr_out), 32'h0);
    chk("rst_rvalid", 32'(rvalid_out), 32'h0);
    cyc(); #3;
    chk("idle_gnt", 32'(gnt_out), 32'h0);
    chk("idle_en", 32'(bram_en_out), 32'h0);
    chk("idle_rvalid", 32'(rvalid_out), 32'h0);

    // single requester 0
    cyc(); req_in = 2'b01; addr0_in = 19'h00123; #3;
    chk("single_gnt", 32'(gnt_out), 32'h1);
    cyc(); req_in = 2'b00; addr0_in = 19'h7ffff; #3;
    chk("single_addr", 32'(bram_addr_out), 32'h123);
    chk("single_en", 32'(bram_en_out), 32'h1);
    chk("single_gnt_off", 32'(gnt_out), 32'h0);
    cyc(); #3;
    chk("single_en_off", 32'(bram_en_out), 32'h0);
    chk("single_addr_hold", 32'(bram_addr_out), 32'h123);
    chk("single_rv_early", 32'(rvalid_out), 32'h0);
    cyc(); #3;
    chk("single_rvalid", 32'(rvalid_out), 32'h1);
    chk("single_rdata", 32'(rdata_out), 32'h1);
    cyc(); #3;
    chk("single_rv_off", 32'(rvalid_out), 32'h0);

    // contention for 20 cycles from a fresh reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
`ifdef MASK_ARB_FIXED_PRIORITY_EN
      exp_id[i] = 1'b0;
`else
      exp_id[i] = (i >= 8 && i < 16);
`endif
    end
    for (int c = 0; c < 23; c++) begin
      cyc();
      req_in   = (c < 20) ? 2'b11 : 2'b00;
      addr0_in = 19'h100 + 19'(c);
      addr1_in = 19'h200 + 19'(c);
      #3;
      if (c < 20) begin
        exp_g = exp_id[c] ? 2'b10 : 2'b01;
        chk($sformatf("cont_gnt[%0d]", c), 32'(gnt_out), 32'(exp_g));
      end
      if (c >= 1 && c <= 20) begin
        chk($sformatf("cont_addr[%0d]", c - 1), 32'(bram_addr_out),
            32'(exp_id[c-1] ? 19'h200 + 19'(c - 1) : 19'h100 + 19'(c - 1)));
        chk($sformatf("cont_en[%0d]", c - 1), 32'(bram_en_out), 32'h1);
      end
      if (c >= 3) begin
        exp_g = exp_id[c-3] ? 2'b10 : 2'b01;
        chk($sformatf("cont_rvalid[%0d]", c - 3), 32'(rvalid_out), 32'(exp_g));
        chk($sformatf("cont_rdata[%0d]", c - 3), 32'(rdata_out), 32'((c - 3) & 1));
      end
    end

    // owner drops: 3 contended grants to 0, then only requester 1, then contention again
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(); req_in = 2'b11; #3;
      chk($sformatf("drop_pre[%0d]", c), 32'(gnt_out), 32'h1);
    end
    cyc(); req_in = 2'b10; #3;
    chk("drop_switch", 32'(gnt_out), 32'h2);
    // burst restarted at 1: requester 1 keeps 7 more grants, then yields
    for (int c = 0; c < 8; c++) begin
      cyc(); req_in = 2'b11; #3;
`ifdef MASK_ARB_FIXED_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (c < 7) ? 2'b10 : 2'b01;
`endif
      chk($sformatf("drop_post[%0d]", c), 32'(gnt_out), 32'(exp_g));
    end

    // reset mid-flight: read granted in cycle 0 must never return
    do_reset();
    cyc(); req_in = 2'b01; addr0_in = 19'h00055; #3;
    chk("mid_gnt", 32'(gnt_out), 32'h1);
    cyc(); rst_in = 1'b0; #3;
    chk("mid_gnt_forced", 32'(gnt_out), 32'h0);
    chk("mid_en", 32'(bram_en_out), 32'h1);
    cyc(); rst_in = 1'b1; req_in = 2'b00; #3;
    chk("mid_en_cleared", 32'(bram_en_out), 32'h0);
    chk("mid_rv2", 32'(rvalid_out), 32'h0);
    cyc(); #3;
    chk("mid_rv3", 32'(rvalid_out), 32'h0);
    cyc(); #3;
    chk("mid_rv4", 32'(rvalid_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
